// File: rtl/tdm_pkg.sv
// Shared definitions for the four-channel TDM link (mux transmitter and demux receiver).
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  // Bit counter wide enough for slot widths up to 16.
  localparam int CNT_W     = 5;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef logic [SLOT_W-1:0] slot_t;
endpackage

// File: rtl/tdm_slot_shifter.sv
// MSB-first slot deserializer: shift register, bit counter and word-done flag.
module tdm_slot_shifter
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_i,
  input  logic             restart_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] word_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH:0]   ext;

  // word_o is the word as it stands after this sample, so a completing
  // bit is visible to the caller on the same edge.
  always_comb begin
    ext     = {sreg_q, din_i};
    sreg_d  = sreg_q;
    cnt_inc = cnt_q;
    done_o  = 1'b0;
    if (shift_i) begin
      if (restart_i) begin
        sreg_d    = '0;
        sreg_d[0] = din_i;
        cnt_inc   = CNT_W'(1);
      end else begin
        sreg_d  = ext[WIDTH-1:0];
        cnt_inc = cnt_q + 1'b1;
      end
      done_o = (cnt_inc == CNT_W'(WIDTH));
    end
    cnt_d = done_o ? '0 : cnt_inc;
  end

  assign word_o = sreg_d;
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
  end

endmodule

// File: rtl/tdm_demux_four.sv
// Four-slot TDM receiver: locks to frame sync, deserializes slots A..D and
// presents them together with a one-cycle valid pulse per frame.
module tdm_demux_four
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             fs,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             valid,
  output logic             s1,
  output logic             s0,
  output logic             locked,
  output logic             sync_err
);

  state_e           state_q, state_d;
  slot_t            slot_q, slot_d, eff_slot;
  logic [WIDTH-1:0] hold_q [NUM_SLOTS];
  logic [WIDTH-1:0] hold_d [NUM_SLOTS];
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
  logic             valid_q, valid_d, err_q, err_d;
  logic             shift, restart, done, boundary;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] bit_cnt;

  tdm_slot_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_i  (shift),
    .restart_i(restart),
    .din_i    (din),
    .word_o   (word),
    .done_o   (done),
    .cnt_o    (bit_cnt)
  );

  assign boundary = (slot_q == '0) && (bit_cnt == '0);

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    hold_d   = hold_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    shift    = 1'b0;
    restart  = 1'b0;
    eff_slot = slot_q;

    if (en) begin
      if (state_q == HUNT) begin
        if (fs) begin
          shift   = 1'b1;
          restart = 1'b1;
          state_d = LOCKED;
        end
      end else if (boundary) begin
        if (fs) begin
          shift   = 1'b1;
          restart = 1'b1;
        end else begin
          // Missing sync: drop this bit and go back to hunting.
          err_d   = 1'b1;
          state_d = HUNT;
          slot_d  = '0;
        end
      end else begin
        shift   = 1'b1;
        restart = fs;
        err_d   = fs;
      end
    end

    if (restart) eff_slot = '0;

    // A restart with WIDTH=1 also completes slot A on the same sample.
    if (shift) begin
      slot_d = eff_slot;
      if (done) begin
        hold_d[eff_slot] = word;
        if (eff_slot == slot_t'(NUM_SLOTS-1)) begin
          a_d     = hold_q[0];
          b_d     = hold_q[1];
          c_d     = hold_q[2];
          d_d     = word;
          valid_d = 1'b1;
          slot_d  = '0;
        end else begin
          slot_d = eff_slot + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign A        = a_q;
  assign B        = b_q;
  assign C        = c_q;
  assign D        = d_q;
  assign valid    = valid_q;
  assign sync_err = err_q;
  assign s1       = slot_q[1];
  assign s0       = slot_q[0];
  assign locked   = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_four.sv
// Bench for tdm_demux_four at WIDTH=1 and WIDTH=4 against a bit-list frame model.
module tb_tdm_demux_four;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, din, fs, sel4;
  logic en1, en4;
  assign en1 = en & ~sel4;
  assign en4 = en & sel4;

  logic       A1, B1, C1, D1, valid1, s1_1, s0_1, locked1, err1;
  logic [3:0] A4, B4, C4, D4;
  logic       valid4, s1_4, s0_4, locked4, err4;

  tdm_demux_four #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .din(din), .fs(fs),
    .A(A1), .B(B1), .C(C1), .D(D1), .valid(valid1),
    .s1(s1_1), .s0(s0_1), .locked(locked1), .sync_err(err1)
  );

  tdm_demux_four #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .din(din), .fs(fs),
    .A(A4), .B(B4), .C(C4), .D(D4), .valid(valid4),
    .s1(s1_4), .s0(s0_4), .locked(locked4), .sync_err(err4)
  );

  // {A,B,C,D,valid,s1,s0,locked,sync_err}
  logic [20:0] obs;
  assign obs = sel4 ? {A4, B4, C4, D4, valid4, s1_4, s0_4, locked4, err4}
                    : {3'b0, A1, 3'b0, B1, 3'b0, C1, 3'b0, D1, valid1, s1_1, s0_1, locked1, err1};

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: the frame is the list of bits collected since its first bit.
  int         mw;
  bit         m_locked;
  bit         mq[$];
  logic [3:0] mA, mB, mC, mD;
  bit         mV, mE;

  function automatic logic [3:0] mword(int s);
    logic [3:0] w = '0;
    for (int i = 0; i < mw; i++) w = {w[2:0], mq[s*mw+i]};
    return w;
  endfunction

  function automatic logic [20:0] expv();
    int sl;
    logic [1:0] s2;
    sl = m_locked ? (mq.size() / mw) : 0;
    s2 = sl[1:0];
    return {mA, mB, mC, mD, mV, s2, m_locked, mE};
  endfunction

  task automatic mreset();
    m_locked = 1'b0;
    mq.delete();
    mA = '0; mB = '0; mC = '0; mD = '0;
    mV = 1'b0; mE = 1'b0;
  endtask

  task automatic cyc(input bit e, input bit d, input bit f);
    en = e; din = d; fs = f;
    mV = 1'b0; mE = 1'b0;
    if (e) begin
      if (!m_locked) begin
        if (f) begin m_locked = 1'b1; mq = {d}; end
      end else if (mq.size() == 0) begin
        if (f) mq = {d};
        else begin mE = 1'b1; m_locked = 1'b0; end
      end else if (f) begin
        mE = 1'b1; mq = {d};
      end else begin
        mq.push_back(d);
      end
      if (m_locked && mq.size() == 4*mw) begin
        mA = mword(0); mB = mword(1); mC = mword(2); mD = mword(3);
        mV = 1'b1;
        mq.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  // Pick a DUT and bring both designs and the model to the reset state.
  task automatic select(input bit s, input int w);
    sel4 = s; mw = w;
    rst_n = 1'b0; en = 1'b1; fs = 1'b1; din = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b0; fs = 1'b0;
    mreset();
    #1;
  endtask

  task automatic test_reset();
    select(1'b0, 1);
    if (obs !== 21'h0) $display("FAIL reset_w1 got %h need %h", obs, 21'h0);
    else n_pass++;
    n_chk++;
    sel4 = 1'b1; #1;
    if (obs !== 21'h0) $display("FAIL reset_w4 got %h need %h", obs, 21'h0);
    else n_pass++;
    n_chk++;
    select(1'b0, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'($urandom), 1'b0);
      if (obs !== 21'h0 || obs !== expv()) $display("FAIL hunt_idle got %h need %h", obs, expv());
      else n_pass++;
      n_chk++;
    end
  endtask

  task automatic test_w1_frame();
    bit b[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, b[i], i == 0);
      if (obs !== expv()) $display("FAIL w1_bit%0d got %h need %h", i, obs, expv());
      else n_pass++;
      n_chk++;
    end
    if (obs !== {4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 2'b00, 1'b1, 1'b0})
      $display("FAIL w1_frame got %h need %h", obs, {4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 2'b00, 1'b1, 1'b0});
    else n_pass++;
    n_chk++;
    cyc(1'b0, 1'b0, 1'b0);
    if (obs[4] !== 1'b0) $display("FAIL w1_valid_pulse got %b need 0", obs[4]);
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_random(input bit s, input int w, input int n);
    bit e, f;
    select(s, w);
    for (int i = 0; i < n; i++) begin
      e = ($urandom_range(0, 3) != 0);
      if (m_locked && mq.size() == 0) f = ($urandom_range(0, 9) != 0);
      else f = ($urandom_range(0, 24) == 0);
      cyc(e, 1'($urandom), f);
      if (obs !== expv()) $display("FAIL rand_w%0d cyc%0d got %h need %h", w, i, obs, expv());
      else n_pass++;
      n_chk++;
    end
  endtask

  task automatic test_w4_two_frames();
    logic [15:0] fr[2] = '{16'hA5C3, 16'h1248};
    select(1'b1, 4);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        cyc(1'b1, fr[k][15-i], i == 0);
        if (obs !== expv() || obs[0] !== 1'b0)
          $display("FAIL w4_f%0d_bit%0d got %h need %h", k, i, obs, expv());
        else n_pass++;
        n_chk++;
      end
      if (obs !== {fr[k], 1'b1, 2'b00, 1'b1, 1'b0})
        $display("FAIL w4_frame%0d got %h need %h", k, obs, {fr[k], 1'b1, 2'b00, 1'b1, 1'b0});
      else n_pass++;
      n_chk++;
    end
  endtask

  task automatic test_en_toggle();
    logic [15:0] fr = 16'hF0F0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, fr[15-i], i == 0);
      if (obs !== expv()) $display("FAIL entog_on%0d got %h need %h", i, obs, expv());
      else n_pass++;
      n_chk++;
      cyc(1'b0, 1'($urandom), 1'($urandom));
      if (obs !== expv()) $display("FAIL entog_off%0d got %h need %h", i, obs, expv());
      else n_pass++;
      n_chk++;
    end
    if (obs[20:5] !== 16'hF0F0) $display("FAIL entog_words got %h need %h", obs[20:5], 16'hF0F0);
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_early_sync();
    logic [15:0] fr = 16'h963E;
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 6; i++) cyc(1'b1, (i == 3), 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, fr[15-i], i == 0);
      if (obs !== expv()) $display("FAIL early_bit%0d got %h need %h", i, obs, expv());
      else n_pass++;
      n_chk++;
      if (i == 0) begin
        if (obs !== {16'hF0F0, 1'b0, 2'b00, 1'b1, 1'b1})
          $display("FAIL early_err got %h need %h", obs, {16'hF0F0, 1'b0, 2'b00, 1'b1, 1'b1});
        else n_pass++;
        n_chk++;
      end
    end
    if (obs !== {16'h963E, 1'b1, 2'b00, 1'b1, 1'b0})
      $display("FAIL early_restart got %h need %h", obs, {16'h963E, 1'b1, 2'b00, 1'b1, 1'b0});
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_missing_sync();
    cyc(1'b1, 1'b1, 1'b0);
    if (obs !== {16'h963E, 1'b0, 2'b00, 1'b0, 1'b1})
      $display("FAIL missing_err got %h need %h", obs, {16'h963E, 1'b0, 2'b00, 1'b0, 1'b1});
    else n_pass++;
    n_chk++;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'($urandom), 1'b0);
      if (obs !== expv() || obs[1] !== 1'b0) $display("FAIL missing_hunt%0d got %h need %h", i, obs, expv());
      else n_pass++;
      n_chk++;
    end
    cyc(1'b1, 1'b1, 1'b1);
    if (obs !== expv() || obs[1] !== 1'b1) $display("FAIL missing_relock got %h need %h", obs, expv());
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'($urandom), 1'b0);
    rst_n = 1'b0; en = 1'b1; fs = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b0; fs = 1'b0;
    mreset();
    if (obs !== 21'h0) $display("FAIL midframe_reset got %h need %h", obs, 21'h0);
    else n_pass++;
    n_chk++;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; din = 1'b0; fs = 1'b0; sel4 = 1'b0; mw = 1;
    mreset();
    test_reset();
    test_w1_frame();
    test_random(1'b0, 1, 400);
    test_w4_two_frames();
    test_en_toggle();
    test_early_sync();
    test_missing_sync();
    test_midframe_reset();
    test_random(1'b1, 4, 800);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
